fib_seq_ctrl: RTL and testbench

- Sequencer for the 3-bit decrement/compare Alu in the Fibonacci datapath.
- Accepts a start request with index n, loads n into the Alu counter path, then steps the counter down one cycle per iteration. In parallel it runs the Fibonacci accumulator pair (a, b).
- Terminates on the Alu less-than flag, presents F(n) with a one-cycle done pulse, and returns to idle.

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_acc.sv | 66 ++++++
 rtl/fib_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_fib_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci sequencer slice.
//   state_e : sequencer FSM states (IDLE, LOAD, RUN, FIN)
//   N_W     : default width of index n, counter ts and Alu dec bus
//   F_W     : default result width
//   FIB_SAT : saturation value for the default result width
// ---------------------------------------------------------------------------
package fib_pkg;

  localparam int N_W = 3;
  localparam int F_W = 8;

  localparam logic [F_W-1:0] FIB_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/fib_acc.sv
// ---------------------------------------------------------------------------
// fib_acc
// Fibonacci accumulator pair (a, b) with a saturating adder.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   init_i in   load a=0, b=1 and clear the overflow flag
//   step_i in   advance one iteration: a<=b, b<=sat(a+b)
//   b_o    out  current b (F(k) after k-1 steps)
//   ovf_o  out  sticky saturation flag, cleared by init_i
// ---------------------------------------------------------------------------
module fib_acc
  import fib_pkg::*;
#(
  parameter int F_W = fib_pkg::F_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init_i,
  input  logic           step_i,
  output logic [F_W-1:0] b_o,
  output logic           ovf_o
);

  logic [F_W-1:0] a_q, a_d;
  logic [F_W-1:0] b_q, b_d;
  logic           ovf_q, ovf_d;
  logic [F_W:0]   sum;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    ovf_d = ovf_q;
    // One extra bit so the carry-out flags saturation directly.
    sum   = {1'b0, a_q} + {1'b0, b_q};
    if (init_i) begin
      a_d   = '0;
      b_d   = F_W'(1);
      ovf_d = 1'b0;
    end else if (step_i) begin
      a_d = b_q;
      if (sum[F_W]) begin
        b_d   = '1;
        ovf_d = 1'b1;
      end else begin
        b_d = sum[F_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ovf_q <= ovf_d;
    end
  end

  assign b_o   = b_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fib_seq_ctrl
// Sequencer for the external 3-bit decrement/compare Alu of the Fibonacci
// datapath. Latches n on an accepted start, loads it into the Alu counter
// path, steps the counter down once per iteration while the accumulator pair
// advances, and presents F(n) with a one-cycle done pulse.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request, accepted only in IDLE (and not with abort)
//   abort     in   synchronous cancel back to IDLE, no done
//   n         in   Fibonacci index, sampled on the accepted start
//   busy      out  high in LOAD, RUN and FIN
//   done      out  one-cycle pulse in FIN
//   result    out  F(n), valid from done until the next accepted start
//   overflow  out  saturation occurred in the current/last run
//   alu_n     out  latched index, to Alu n
//   alu_ts    out  counter register, to Alu ts
//   alu_ins   out  Alu select: 1 = dec returns n, 0 = dec returns ts-1
//   alu_modes out  Alu compare mode (always 0: lt means ts<=1)
//   alu_dec   in   Alu mux/decrement output
//   alu_lt    in   Alu terminal flag
// ---------------------------------------------------------------------------
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int N_W = fib_pkg::N_W,
  parameter int F_W = fib_pkg::F_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic [F_W-1:0] result,
  output logic           overflow,
  output logic [N_W-1:0] alu_n,
  output logic [N_W-1:0] alu_ts,
  output logic           alu_ins,
  output logic           alu_modes,
  input  logic [N_W-1:0] alu_dec,
  input  logic           alu_lt
);

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [N_W-1:0] ts_q, ts_d;
  logic [F_W-1:0] result_q, result_d;
  logic [F_W-1:0] fin_val;
  logic           acc_init;
  logic           acc_step;
  logic [F_W-1:0] acc_b;
  logic           acc_ovf;

  fib_acc #(
    .F_W(F_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .init_i(acc_init),
    .step_i(acc_step),
    .b_o   (acc_b),
    .ovf_o (acc_ovf)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ts_d     = ts_q;
    result_d = result_q;
    acc_init = 1'b0;
    acc_step = 1'b0;
    alu_ins  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    // F(0) is 0, but the accumulator starts with b=1, so n=0 is special-cased.
    fin_val  = (n_q == '0) ? '0 : acc_b;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          n_d     = n;
          state_d = LOAD;
        end
      end
      LOAD: begin
        alu_ins = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          ts_d     = alu_dec;
          acc_init = 1'b1;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (alu_lt) begin
          state_d = FIN;
        end else begin
          acc_step = 1'b1;
          ts_d     = alu_dec;
        end
      end
      FIN: begin
        // An abort here drops the pulse and leaves result untouched.
        state_d = IDLE;
        if (!abort) begin
          done     = 1'b1;
          result_d = fin_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      ts_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ts_q     <= ts_d;
      result_q <= result_d;
    end
  end

  // The register only captures F(n) at the end of FIN; bypass it during the
  // done cycle so result is already valid alongside the pulse.
  assign result    = done ? fin_val : result_q;
  assign overflow  = acc_ovf;
  assign alu_n     = n_q;
  assign alu_ts    = ts_q;
  assign alu_modes = 1'b0;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Testbench for fib_seq_ctrl: table-driven sweep plus hand-written sequences,
// with a done-driven scoreboard on the main instance.
module tb_fib_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] n = 3'd0;
  logic       busy, done, overflow, alu_ins, alu_modes, alu_lt;
  logic [7:0] result;
  logic [2:0] alu_n, alu_ts, alu_dec;

  // Narrow instance: F(7)=13 fits in 4 bits, so a 3-bit result forces saturation.
  logic       start_s = 1'b0;
  logic       abort_s = 1'b0;
  logic [2:0] n_s = 3'd0;
  logic       busy_s, done_s, overflow_s, alu_ins_s, alu_modes_s, alu_lt_s;
  logic [2:0] result_s;
  logic [2:0] alu_n_s, alu_ts_s, alu_dec_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int res; int ovf; int cyc; } exp_t;
  exp_t exp_q[$];

  typedef struct { logic [2:0] n; int res; int lat; } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Alu: dec = ins ? n : ts-1 ; lt = (ts<=1) in mode 0.
  assign alu_dec   = alu_ins ? alu_n : alu_ts - 3'd1;
  assign alu_lt    = (alu_modes == 1'b0) ? (alu_ts <= 3'd1) : 1'b0;
  assign alu_dec_s = alu_ins_s ? alu_n_s : alu_ts_s - 3'd1;
  assign alu_lt_s  = (alu_modes_s == 1'b0) ? (alu_ts_s <= 3'd1) : 1'b0;

  fib_seq_ctrl #(.N_W(3), .F_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n(n),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .alu_n(alu_n), .alu_ts(alu_ts), .alu_ins(alu_ins), .alu_modes(alu_modes),
    .alu_dec(alu_dec), .alu_lt(alu_lt)
  );

  fib_seq_ctrl #(.N_W(3), .F_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .n(n_s),
    .busy(busy_s), .done(done_s), .result(result_s), .overflow(overflow_s),
    .alu_n(alu_n_s), .alu_ts(alu_ts_s), .alu_ins(alu_ins_s), .alu_modes(alu_modes_s),
    .alu_dec(alu_dec_s), .alu_lt(alu_lt_s)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_overflow", overflow, e.ovf);
        chk("sb_done_cycle", cyc, e.cyc);
        $display("txn: done at cycle %0d result=%0d overflow=%0d", cyc, result, overflow);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_one(input logic [2:0] n0, input logic [2:0] n_late,
                         input int exp_res, input int exp_ovf);
    int lat;
    int t0;
    lat = 2 + ((n0 > 3'd1) ? int'(n0) : 1);
    t0 = cyc;
    start = 1'b1;
    n = n0;
    exp_q.push_back('{exp_res, exp_ovf, t0 + lat});
    $display("txn: start n=%0d at cycle %0d expect result=%0d at cycle %0d", n0, t0, exp_res, t0 + lat);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int k = 1; k <= lat; k++) begin
      step();
      start = 1'b0;
      if (k == 3) n = n_late;
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done_timing", done, (k == lat) ? 1 : 0);
      if (k == 1) begin
        chk("load_alu_ins", alu_ins, 1);
        chk("load_alu_n", alu_n, n0);
      end else if (k < lat) begin
        chk("run_alu_ins", alu_ins, 0);
        chk("run_alu_ts", alu_ts, int'(n0) - (k - 2));
        chk("run_alu_modes", alu_modes, 0);
      end
    end
    step();
    @(negedge clk);
    chk("post_busy", busy, 0);
    step();
  endtask

  task automatic sat_run(input logic [2:0] n0, input int exp_res, input int exp_ovf);
    int lat;
    lat = 2 + ((n0 > 3'd1) ? int'(n0) : 1);
    start_s = 1'b1;
    n_s = n0;
    for (int k = 1; k <= lat; k++) begin
      step();
      start_s = 1'b0;
      @(negedge clk);
      chk("sat_done", done_s, (k == lat) ? 1 : 0);
      if (k == lat) begin
        chk("sat_result", result_s, exp_res);
        chk("sat_overflow", overflow_s, exp_ovf);
        $display("txn: sat n=%0d result=%0d overflow=%0d", n0, result_s, overflow_s);
      end
    end
    step();
  endtask

  initial begin
    int t0;
    tbl[0] = '{3'd0, 0, 3};  tbl[1] = '{3'd1, 1, 3};
    tbl[2] = '{3'd2, 1, 4};  tbl[3] = '{3'd3, 2, 5};
    tbl[4] = '{3'd4, 3, 6};  tbl[5] = '{3'd5, 5, 7};
    tbl[6] = '{3'd6, 8, 8};  tbl[7] = '{3'd7, 13, 9};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_alu_ins", alu_ins, 0);
    chk("rst_alu_modes", alu_modes, 0);
    chk("rst_alu_ts", alu_ts, 0);
    chk("rst_alu_n", alu_n, 0);
    step();
    rst_n = 1'b1;
    step();

    // Sweep n = 0..7 (latency comes from the table, not from the DUT)
    for (int i = 0; i < 8; i++) begin
      chk("tbl_latency", tbl[i].lat, 2 + ((tbl[i].n > 3'd1) ? int'(tbl[i].n) : 1));
      run_one(tbl[i].n, tbl[i].n, tbl[i].res, 0);
    end

    // Abort in the third RUN cycle; LOAD already cleared result to 0
    t0 = cyc;
    start = 1'b1; n = 3'd7;
    step(); start = 1'b0;
    step(); step();
    step(); abort = 1'b1;
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    chk("abort_done", done, 0);
    step(); abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_result_hold", result, 0);
    chk("abort_overflow_hold", overflow, 0);
    $display("txn: abort n=7 started cycle %0d, idle at cycle %0d", t0, cyc);
    run_one(3'd3, 3'd3, 2, 0);

    // Abort in FIN suppresses done; result keeps the LOAD-cleared value
    start = 1'b1; n = 3'd1;
    step(); start = 1'b0;
    step();
    step(); abort = 1'b1;
    #1;
    chk("fin_abort_busy", busy, 1);
    chk("fin_abort_done", done, 0);
    chk("fin_abort_result", result, 0);
    step(); abort = 1'b0;
    chk("fin_abort_idle", busy, 0);
    chk("fin_abort_result_after", result, 0);
    $display("txn: abort in FIN at cycle %0d", cyc - 1);
    step();

    // Start held high for 12 cycles with n=4: runs accepted at T and T+7
    t0 = cyc;
    start = 1'b1; n = 3'd4;
    exp_q.push_back('{3, 0, t0 + 6});
    exp_q.push_back('{3, 0, t0 + 13});
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 7) chk("hold_reaccept_idle", busy, 0);
      if (i == 8) chk("hold_reaccept_busy", busy, 1);
    end
    step(); start = 1'b0;
    step(); step();
    chk("hold_final_idle", busy, 0);
    step();
    chk("hold_two_runs", exp_q.size(), 0);
    $display("txn: held start from cycle %0d, two runs expected", t0);

    // n changes during RUN: latched index still wins
    run_one(3'd4, 3'd7, 3, 0);

    // Reset mid-RUN with n=6
    start = 1'b1; n = 3'd6;
    step(); start = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_alu_ts", alu_ts, 0);
    chk("midrst_alu_n", alu_n, 0);
    $display("txn: reset mid-run at cycle %0d", cyc);
    step();
    step(); rst_n = 1'b1;
    step();
    run_one(3'd2, 3'd2, 1, 0);

    // Saturation on the 3-bit instance, then a clean run clears overflow
    sat_run(3'd7, 7, 1);
    sat_run(3'd3, 2, 0);

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
